sys_cmd_frame_ctrl: RTL and testbench

//  Command-frame parser downstream of the RX-side bus synchronizer. Consumes synchronized bytes,

---
 rtl/sys_cmd_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_sys_cmd_frame_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_frame_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sys_cmd_frame_ctrl: decodes 1-4 byte RX command frames into reg-file/ALU strobes. Rev 1.0
// ----------------------------------------------------------------------------
module sys_cmd_frame_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int FUN_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  alu_en,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic                  busy,
  output logic                  cmd_err,
  output logic                  frame_err
);

  localparam int                    C_CNT_WIDTH = $clog2(TIMEOUT_CYC);
  localparam logic [C_CNT_WIDTH-1:0] C_TERM     = C_CNT_WIDTH'(TIMEOUT_CYC - 1);
  localparam logic [DATA_WIDTH-1:0] C_OP_WRITE  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] C_OP_READ   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] C_OP_ALU    = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] C_OP_ALU_NP = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_ALU_A   = 3'd4,
    S_ALU_B   = 3'd5,
    S_ALU_FUN = 3'd6
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [C_CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr_lat, w_addr_lat_nxt;
  logic                    w_wr_en, w_rd_en, w_alu_en, w_cmd_err, w_frame_err;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wr_data;
  logic [FUN_WIDTH-1:0]    w_alu_fun;
  logic                    w_timeout;

  // A byte landing on the terminal count wins over the timeout.
  assign w_timeout = (r_state != S_IDLE) && !rx_valid && (r_cnt == C_TERM);

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_lat_nxt = r_addr_lat;
    w_wr_en        = 1'b0;
    w_rd_en        = 1'b0;
    w_alu_en       = 1'b0;
    w_cmd_err      = 1'b0;
    w_frame_err    = 1'b0;
    w_addr         = addr;
    w_wr_data      = wr_data;
    w_alu_fun      = alu_fun;
    if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == C_OP_WRITE)       w_state_nxt = S_WR_ADDR;
          else if (rx_data == C_OP_READ)   w_state_nxt = S_RD_ADDR;
          else if (rx_data == C_OP_ALU)    w_state_nxt = S_ALU_A;
          else if (rx_data == C_OP_ALU_NP) w_state_nxt = S_ALU_FUN;
          else                             w_cmd_err   = 1'b1;
        end
        S_WR_ADDR: begin
          w_addr_lat_nxt = rx_data[ADDR_WIDTH-1:0];
          w_state_nxt    = S_WR_DATA;
        end
        S_WR_DATA: begin
          w_wr_en     = 1'b1;
          w_addr      = r_addr_lat;
          w_wr_data   = rx_data;
          w_state_nxt = S_IDLE;
        end
        S_RD_ADDR: begin
          w_rd_en     = 1'b1;
          w_addr      = rx_data[ADDR_WIDTH-1:0];
          w_state_nxt = S_IDLE;
        end
        S_ALU_A: begin
          w_wr_en     = 1'b1;
          w_addr      = ADDR_WIDTH'(0);
          w_wr_data   = rx_data;
          w_state_nxt = S_ALU_B;
        end
        S_ALU_B: begin
          w_wr_en     = 1'b1;
          w_addr      = ADDR_WIDTH'(1);
          w_wr_data   = rx_data;
          w_state_nxt = S_ALU_FUN;
        end
        S_ALU_FUN: begin
          w_alu_en    = 1'b1;
          w_alu_fun   = rx_data[FUN_WIDTH-1:0];
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_frame_err = 1'b1;
      w_state_nxt = S_IDLE;
    end

    // Held at zero in IDLE, cleared per byte, saturates rather than wrapping.
    w_cnt_nxt = r_cnt;
    if (w_state_nxt == S_IDLE || rx_valid) w_cnt_nxt = '0;
    else if (r_cnt != C_TERM)              w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr_lat <= '0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      alu_en     <= 1'b0;
      addr       <= '0;
      wr_data    <= '0;
      alu_fun    <= '0;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr_lat <= w_addr_lat_nxt;
      wr_en      <= w_wr_en;
      rd_en      <= w_rd_en;
      alu_en     <= w_alu_en;
      addr       <= w_addr;
      wr_data    <= w_wr_data;
      alu_fun    <= w_alu_fun;
      busy       <= (w_state_nxt != S_IDLE);
      cmd_err    <= w_cmd_err;
      frame_err  <= w_frame_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_cmd_frame_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sys_cmd_frame_ctrl: directed + random frames against a frame-level reference model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_sys_cmd_frame_ctrl;

  localparam int T = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       wr_en, rd_en, alu_en, busy, cmd_err, frame_err;
  logic [3:0] addr, alu_fun;
  logic [7:0] wr_data;

  int total = 0;
  int bad   = 0;

  sys_cmd_frame_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYC(T)
  ) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .alu_en(alu_en), .alu_fun(alu_fun), .busy(busy),
    .cmd_err(cmd_err), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  // Reference model: bytes of the open frame, and the cycle its last byte arrived.
  logic [7:0] fq[$];
  int         cyc = 0;
  int         last_cyc = 0;
  logic       e_wr = 0, e_rd = 0, e_alu = 0, e_busy = 0, e_cerr = 0, e_ferr = 0;
  logic [3:0] e_addr = 0, e_fun = 0;
  logic [7:0] e_data = 0;

  task automatic model_reset();
    fq.delete();
    {e_wr, e_rd, e_alu, e_busy, e_cerr, e_ferr} = '0;
    e_addr = 0; e_fun = 0; e_data = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    int n;
    {e_wr, e_rd, e_alu, e_cerr, e_ferr} = '0;
    if (v) begin
      last_cyc = cyc;
      if (fq.size() == 0) begin
        if (d inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) fq.push_back(d);
        else e_cerr = 1'b1;
      end else begin
        fq.push_back(d);
        n = fq.size();
        case (fq[0])
          8'hAA: if (n == 3) begin
            e_wr = 1; e_addr = 4'(fq[1] % 16); e_data = fq[2]; fq.delete();
          end
          8'hBB: if (n == 2) begin
            e_rd = 1; e_addr = 4'(fq[1] % 16); fq.delete();
          end
          8'hCC: begin
            if (n == 2) begin e_wr = 1; e_addr = 0; e_data = fq[1]; end
            if (n == 3) begin e_wr = 1; e_addr = 1; e_data = fq[2]; end
            if (n == 4) begin e_alu = 1; e_fun = 4'(fq[3] % 16); fq.delete(); end
          end
          default: if (n == 2) begin
            e_alu = 1; e_fun = 4'(fq[1] % 16); fq.delete();
          end
        endcase
      end
    end else if (fq.size() > 0 && (cyc - last_cyc) == T) begin
      e_ferr = 1'b1;
      fq.delete();
    end
    e_busy = (fq.size() > 0);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("alu_en", 32'(alu_en), 32'(e_alu));
    chk("addr", 32'(addr), 32'(e_addr));
    chk("wr_data", 32'(wr_data), 32'(e_data));
    chk("alu_fun", 32'(alu_fun), 32'(e_fun));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cmd_err", 32'(cmd_err), 32'(e_cerr));
    chk("frame_err", 32'(frame_err), 32'(e_ferr));
    chk("strobe_onehot", 32'(int'(wr_en) + int'(rd_en) + int'(alu_en) <= 1), 32'd1);
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge CLK);
    model_step(v, d);
    #1;
    check_all();
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) tick(1'b0, 8'h00);
    tick(1'b1, b);
  endtask

  task automatic do_reset();
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    check_all();
    RST = 1'b1;
  endtask

  initial begin
    int r, len, g;
    logic [7:0] op;

    // Power-on reset, then reset in the middle of a WRITE frame.
    do_reset();
    send(8'hAA, 0); send(8'h03, 3);
    do_reset();
    chk("t1_busy_after_rst", 32'(busy), 32'd0);
    send(8'hAA, 2); send(8'h05, 3); send(8'h3C, 3);
    chk("t1_wr", 32'(wr_en), 32'd1);
    chk("t1_addr", 32'(addr), 32'd5);
    chk("t1_data", 32'(wr_data), 32'h3C);

    // WRITE with pulses four cycles apart.
    send(8'hAA, 3); send(8'h03, 3); send(8'h5A, 3);
    chk("t2_wr", 32'(wr_en), 32'd1);
    chk("t2_addr", 32'(addr), 32'd3);
    chk("t2_data", 32'(wr_data), 32'h5A);
    chk("t2_busy", 32'(busy), 32'd0);
    tick(1'b0, 8'h00);

    // READ, upper address nibble ignored.
    send(8'hBB, 1); send(8'h17, 1);
    chk("t3_rd", 32'(rd_en), 32'd1);
    chk("t3_addr", 32'(addr), 32'd7);

    // ALU_OP: two register writes then the ALU start.
    send(8'hCC, 1); send(8'h10, 1);
    chk("t4_wrA_addr", 32'(addr), 32'd0);
    chk("t4_wrA_data", 32'(wr_data), 32'h10);
    send(8'h20, 1);
    chk("t4_wrB_addr", 32'(addr), 32'd1);
    chk("t4_wrB_data", 32'(wr_data), 32'h20);
    send(8'h02, 1);
    chk("t4_alu", 32'(alu_en), 32'd1);
    chk("t4_fun", 32'(alu_fun), 32'd2);

    // Unknown opcode, then ALU_NP.
    send(8'h55, 2);
    chk("t5_cmd_err", 32'(cmd_err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    send(8'hDD, 1); send(8'h01, 1);
    chk("t5_alu", 32'(alu_en), 32'd1);
    chk("t5_fun", 32'(alu_fun), 32'd1);

    // Timeout after the second byte, then a third byte exactly on the terminal cycle.
    send(8'hAA, 2); send(8'h04, 0);
    repeat (T - 1) tick(1'b0, 8'h00);
    chk("t6_no_early_ferr", 32'(frame_err), 32'd0);
    tick(1'b0, 8'h00);
    chk("t6_ferr", 32'(frame_err), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_no_wr", 32'(wr_en), 32'd0);
    send(8'hAA, 2); send(8'h04, 0); send(8'h7E, T - 1);
    chk("t6_term_wr", 32'(wr_en), 32'd1);
    chk("t6_term_ferr", 32'(frame_err), 32'd0);

    // Randomized frames with random gaps, including terminal-cycle and timeout gaps.
    for (int f = 0; f < 250; f++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2)      begin op = 8'hAA; len = 3; end
      else if (r < 4) begin op = 8'hBB; len = 2; end
      else if (r < 6) begin op = 8'hCC; len = 4; end
      else if (r < 8) begin op = 8'hDD; len = 2; end
      else            begin op = 8'($urandom); len = 1; end
      send(op, int'($urandom_range(0, 3)));
      for (int k = 1; k < len; k++) begin
        if ($urandom_range(0, 11) == 0) g = ($urandom_range(0, 1) == 0) ? T - 1 : T;
        else g = int'($urandom_range(0, 3));
        send(8'($urandom), g);
      end
      if ($urandom_range(0, 39) == 0) begin
        send(8'hCC, 1);
        do_reset();
      end
    end
    repeat (T + 2) tick(1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
